// File: rtl/uart_wb_master.sv
// uart_wb_master: WISHBONE initiator that programs MiniUART divisors, then polls LSR to move
// bytes between the DATA register and valid/ready byte streams.
module uart_wb_master #(
    parameter logic [31:0] DIVT_VAL    = 32'h9,
    parameter logic [31:0] DIVR_VAL    = 32'h9,
    parameter logic [2:0]  OFF_DATA    = 3'd0,
    parameter logic [2:0]  OFF_LSR     = 3'd1,
    parameter logic [2:0]  OFF_DIVR    = 3'd2,
    parameter logic [2:0]  OFF_DIVT    = 3'd3,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [2:0]  wb_off,
    output logic [31:0] wb_dout,
    input  logic [31:0] wb_din,
    output logic        wb_stb,
    output logic        wb_we,
    input  logic        wb_ack,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done,
    output logic        err
);
    typedef enum logic [2:0] {INIT_T, INIT_R, POLL, CHK, RD, WR, GAP} state_t;
    state_t      state, state_n;
    logic [2:0]  off_n;
    logic [31:0] dout_n;
    logic [7:0]  rdata, rx_data_n, tx_buf, tx_buf_n;
    logic [15:0] cnt, cnt_n;
    logic [1:0]  lsr, lsr_n;
    logic        stb_n, we_n, init_done_n, err_n, tx_ready_n, rx_valid_n;
    logic        tx_full, tx_full_n, prio, prio_n, to_init, to_init_n;
    logic        launch, done, tmo, rdy, thre, go_rd;
    logic        unused_din;

    assign unused_din = ^wb_din[31:8];

    always_comb begin
        tmo = wb_stb && !wb_ack && cnt == 16'(ACK_TIMEOUT - 1);
        done = wb_stb && (wb_ack || tmo);
        rdata = wb_ack ? wb_din[7:0] : 8'h0;
        rdy = lsr[0] && !rx_valid;
        thre = lsr[1] && tx_full;
        go_rd = rdy && (!thre || !prio);
        state_n = state;
        stb_n = wb_stb;
        we_n = wb_we;
        off_n = wb_off;
        dout_n = wb_dout;
        init_done_n = init_done;
        err_n = err || tmo;
        lsr_n = lsr;
        prio_n = prio;
        to_init_n = to_init;
        launch = 1'b0;
        cnt_n = (wb_stb && !done) ? cnt + 16'd1 : 16'd0;
        tx_full_n = tx_full;
        tx_buf_n = tx_buf;
        rx_valid_n = rx_valid && !rx_ready;
        rx_data_n = rx_data;
        if (tx_valid && tx_ready) begin
            tx_full_n = 1'b1;
            tx_buf_n = tx_data;
        end
        if (done) begin
            stb_n = 1'b0;
            we_n = 1'b0;
            dout_n = 32'h0;
        end
        case (state)
            CHK: begin
                state_n = go_rd ? RD : thre ? WR : GAP;
                launch = rdy || thre;
                prio_n = prio ^ (rdy && thre);
            end
            GAP: begin
                state_n = to_init ? INIT_R : POLL;
                to_init_n = 1'b0;
                launch = 1'b1;
            end
            default: begin
                // only reachable with stb low right after reset
                launch = !wb_stb;
                if (done) begin
                    state_n = state == POLL ? CHK : GAP;
                    to_init_n = state == INIT_T;
                    init_done_n = init_done || state == INIT_R;
                    lsr_n = state == POLL ? {rdata[5], rdata[0]} : lsr;
                    tx_full_n = state == WR ? 1'b0 : tx_full_n;
                    rx_valid_n = state == RD ? 1'b1 : rx_valid_n;
                    rx_data_n = state == RD ? rdata : rx_data;
                end
            end
        endcase
        if (launch) begin
            stb_n = 1'b1;
            we_n = state_n inside {INIT_T, INIT_R, WR};
            off_n = state_n == INIT_T ? OFF_DIVT : state_n == INIT_R ? OFF_DIVR :
                    state_n == POLL ? OFF_LSR : OFF_DATA;
            dout_n = state_n == INIT_T ? DIVT_VAL : state_n == INIT_R ? DIVR_VAL :
                     state_n == WR ? {24'h0, tx_buf} : 32'h0;
        end
        tx_ready_n = !tx_full_n && init_done_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT_T;
            wb_stb <= 1'b0;
            wb_we <= 1'b0;
            wb_off <= 3'h0;
            wb_dout <= 32'h0;
            init_done <= 1'b0;
            err <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data <= 8'h0;
            tx_full <= 1'b0;
            tx_buf <= 8'h0;
            lsr <= 2'b0;
            prio <= 1'b0;
            to_init <= 1'b0;
            cnt <= 16'd0;
        end else begin
            state <= state_n;
            wb_stb <= stb_n;
            wb_we <= we_n;
            wb_off <= off_n;
            wb_dout <= dout_n;
            init_done <= init_done_n;
            err <= err_n;
            tx_ready <= tx_ready_n;
            rx_valid <= rx_valid_n;
            rx_data <= rx_data_n;
            tx_full <= tx_full_n;
            tx_buf <= tx_buf_n;
            lsr <= lsr_n;
            prio <= prio_n;
            to_init <= to_init_n;
            cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: directed bench with a single-cycle-ack slave model and DATA access log.
module tb_uart_wb_master;
    logic        clk, rst;
    logic [2:0]  wb_off;
    logic [31:0] wb_dout, wb_din;
    logic        wb_stb, wb_we, wb_ack;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, init_done, err;
    logic        ack_en;
    logic [31:0] lsr_val, rd_val;
    logic [35:0] data_log[$];
    int          n_vec, n_err, polls, gap_viol;
    logic        pv_stb, pv_ack;

    uart_wb_master dut (
        .clk(clk), .rst(rst), .wb_off(wb_off), .wb_dout(wb_dout), .wb_din(wb_din),
        .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .init_done(init_done), .err(err)
    );

    assign wb_ack = wb_stb && ack_en;
    assign wb_din = (wb_off == 3'd1) ? lsr_val : rd_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wb_stb && wb_ack && wb_off == 3'd0) data_log.push_back({wb_we, wb_off, wb_dout});
        if (wb_stb && wb_ack && wb_off == 3'd1) polls++;
    end

    always @(negedge clk) begin
        if (pv_stb && pv_ack && wb_stb) gap_viol++;
        pv_stb = wb_stb;
        pv_ack = wb_ack;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int i, n, p0;
        n_vec = 0; n_err = 0; polls = 0; gap_viol = 0; pv_stb = 0; pv_ack = 0;
        rst = 1; ack_en = 1; lsr_val = 0; rd_val = 0;
        tx_data = 0; tx_valid = 0; rx_ready = 0;
        repeat (3) @(posedge clk);
        tick();
        chk("rst_outs", {wb_stb, wb_we, wb_off, init_done, err, tx_ready, rx_valid, rx_data}, 0);
        chk("rst_dout", wb_dout, 0);
        rst = 0;
        tick();
        chk("divt_acc", {wb_stb, wb_we, wb_off}, {1'b1, 1'b1, 3'd3});
        chk("divt_val", wb_dout, 32'h9);
        tick();
        chk("init_gap", {wb_stb, wb_dout}, 0);
        tick();
        chk("divr_acc", {wb_stb, wb_we, wb_off, init_done}, {1'b1, 1'b1, 3'd2, 1'b0});
        chk("divr_val", wb_dout, 32'h9);
        tick();
        chk("init_done", {init_done, wb_stb, tx_ready}, 3'b101);
        tick();
        chk("poll_acc", {wb_stb, wb_we, wb_off, wb_dout}, {1'b1, 1'b0, 3'd1, 32'h0});

        lsr_val = 32'h20; tx_data = 8'h12; tx_valid = 1;
        tick();
        tx_valid = 0;
        chk("tx_taken", tx_ready, 0);
        i = 0;
        while (data_log.size() == 0 && i < 40) begin tick(); i++; end
        chk("wr_seen", data_log.size(), 1);
        chk("wr_entry", data_log[0], {1'b1, 3'd0, 32'h12});
        chk("tx_ready_back", tx_ready, 1);

        data_log.delete();
        lsr_val = 32'h21; rd_val = 32'hFFFF_FFA5;
        i = 0;
        while (!rx_valid && i < 40) begin tick(); i++; end
        chk("rx_valid", rx_valid, 1);
        chk("rx_data", rx_data, 8'hA5);
        chk("rd_entry", data_log[0], {1'b0, 3'd0, 32'h0});
        p0 = polls;
        repeat (30) tick();
        chk("rx_blocks", data_log.size(), 1);
        chk("rx_held", {rx_valid, rx_data}, {1'b1, 8'hA5});
        chk("polls_go", polls > p0 + 3, 1);
        lsr_val = 0;
        repeat (8) tick();
        rx_ready = 1;
        tick();
        rx_ready = 0;
        chk("rx_taken", rx_valid, 0);

        tx_data = 8'h34; tx_valid = 1;
        tick();
        tx_valid = 0;
        data_log.delete();
        lsr_val = 32'h21; rx_ready = 1;
        i = 0;
        while (data_log.size() < 2 && i < 60) begin tick(); i++; end
        chk("alt_cnt", data_log.size() >= 2, 1);
        chk("alt_rd", data_log[0], {1'b0, 3'd0, 32'h0});
        chk("alt_wr", data_log[1], {1'b1, 3'd0, 32'h34});
        lsr_val = 0;
        repeat (8) tick();
        rx_ready = 0;

        chk("err_clear", err, 0);
        ack_en = 0;
        i = 0;
        while (wb_stb && i < 40) begin tick(); i++; end
        while (!wb_stb && i < 40) begin tick(); i++; end
        chk("tmo_wait", i < 40, 1);
        n = 0;
        while (wb_stb && n < 40) begin tick(); n++; end
        chk("tmo_len", n, 16);
        chk("err_set", err, 1);
        ack_en = 1;
        p0 = polls;
        repeat (20) tick();
        chk("err_sticky", err, 1);
        chk("poll_after", polls > p0, 1);

        lsr_val = 32'h20; tx_data = 8'h56; tx_valid = 1;
        tick();
        tx_valid = 0;
        i = 0;
        while (!(wb_stb && wb_we && wb_off == 3'd0) && i < 40) begin tick(); i++; end
        chk("wr_mid", {wb_stb, wb_we, wb_off}, {1'b1, 1'b1, 3'd0});
        rst = 1;
        tick();
        chk("rst_mid", {wb_stb, init_done, tx_ready, err}, 0);
        rst = 0;
        tick();
        chk("restart", {wb_stb, wb_we, wb_off}, {1'b1, 1'b1, 3'd3});
        chk("restart_v", wb_dout, 32'h9);
        i = 0;
        while (!init_done && i < 20) begin tick(); i++; end
        chk("reinit", init_done, 1);
        chk("gap_viol", gap_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
